// File: rtl/psa_pkg.sv
// Shared types and saturation constants for the parallel sub-word adder.
package psa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } psa_state_e;

  function automatic logic [31:0] lane_max(input int lane_w);
    return (32'd1 << (lane_w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] lane_min(input int lane_w);
    return 32'd1 << (lane_w - 1);
  endfunction

endpackage

// File: rtl/psa_lane.sv
// One signed lane: add or subtract with overflow detection and optional saturation.
module psa_lane
  import psa_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic              sat_en,
  output logic [LANE_W-1:0] res,
  output logic              ovfl
);

  localparam logic [LANE_W-1:0] SAT_MAX = LANE_W'(lane_max(LANE_W));
  localparam logic [LANE_W-1:0] SAT_MIN = LANE_W'(lane_min(LANE_W));

  logic [LANE_W:0] ext_a_s;
  logic [LANE_W:0] ext_b_s;
  logic [LANE_W:0] r_s;

  assign ext_a_s = {a[LANE_W-1], a};
  assign ext_b_s = {b[LANE_W-1], b};

  // Extended-precision result; the top two bits disagree exactly on overflow
  always_comb begin
    if (sub) begin
      r_s = ext_a_s - ext_b_s;
    end else begin
      r_s = ext_a_s + ext_b_s;
    end
  end

  assign ovfl = r_s[LANE_W] ^ r_s[LANE_W-1];

  // Clamp toward the true sign of r when saturating, otherwise keep the wrapped bits
  always_comb begin
    if (ovfl && sat_en) begin
      if (r_s[LANE_W]) begin
        res = SAT_MIN;
      end else begin
        res = SAT_MAX;
      end
    end else begin
      res = r_s[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/psa_seq.sv
// Multi-cycle parallel sub-word adder/subtractor: LANES_PER_CYC lanes per clock
// under a start/busy/done handshake.
module psa_seq
  import psa_pkg::*;
#(
  parameter  int LANE_W        = 4,
  parameter  int NUM_LANES     = 4,
  parameter  int LANES_PER_CYC = 1,
  localparam int DATA_W        = LANE_W * NUM_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    A,
  input  logic [DATA_W-1:0]    B,
  input  logic                 sub,
  input  logic                 sat_en,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_W-1:0]    Sum,
  output logic [NUM_LANES-1:0] lane_ovfl,
  output logic                 Error
);

  localparam int N_CHUNK = NUM_LANES / LANES_PER_CYC;
  localparam int CHUNK_W = LANE_W * LANES_PER_CYC;
  localparam int CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNK - 1);

  psa_state_e          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic                sub_r;
  logic                sat_r;

  int                     lane_base_s;
  logic [CHUNK_W-1:0]     chunk_a_s;
  logic [CHUNK_W-1:0]     chunk_b_s;
  logic [CHUNK_W-1:0]     chunk_res_s;
  logic [LANES_PER_CYC-1:0] chunk_ovfl_s;
  logic [DATA_W-1:0]      sum_nxt_s;
  logic [NUM_LANES-1:0]   ovfl_nxt_s;

  // Select the current chunk of captured operands and merge its results into the held outputs
  always_comb begin
    lane_base_s = int'(cnt_r) * LANES_PER_CYC;
    chunk_a_s   = a_r[lane_base_s*LANE_W +: CHUNK_W];
    chunk_b_s   = b_r[lane_base_s*LANE_W +: CHUNK_W];
    sum_nxt_s   = Sum;
    sum_nxt_s[lane_base_s*LANE_W +: CHUNK_W] = chunk_res_s;
    ovfl_nxt_s  = lane_ovfl;
    ovfl_nxt_s[lane_base_s +: LANES_PER_CYC] = chunk_ovfl_s;
  end

  for (genvar g = 0; g < LANES_PER_CYC; g++) begin : g_lane
    psa_lane #(
      .LANE_W(LANE_W)
    ) u_lane (
      .a      (chunk_a_s[g*LANE_W +: LANE_W]),
      .b      (chunk_b_s[g*LANE_W +: LANE_W]),
      .sub    (sub_r),
      .sat_en (sat_r),
      .res    (chunk_res_s[g*LANE_W +: LANE_W]),
      .ovfl   (chunk_ovfl_s[g])
    );
  end

  // Control FSM with operand capture and registered handshake/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      a_r       <= {DATA_W{1'b0}};
      b_r       <= {DATA_W{1'b0}};
      sub_r     <= 1'b0;
      sat_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Sum       <= {DATA_W{1'b0}};
      lane_ovfl <= {NUM_LANES{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r       <= A;
            b_r       <= B;
            sub_r     <= sub;
            sat_r     <= sat_en;
            cnt_r     <= {CNT_W{1'b0}};
            Sum       <= {DATA_W{1'b0}};
            lane_ovfl <= {NUM_LANES{1'b0}};
            busy      <= 1'b1;
            done      <= 1'b0;
            state_r   <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          Sum       <= sum_nxt_s;
          lane_ovfl <= ovfl_nxt_s;
          if (cnt_r == LAST_CNT) begin
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign Error = |lane_ovfl;

endmodule

// File: tb/tb_psa_seq.sv
// Self-checking bench for psa_seq: lane-level reference model, per-cycle compare, directed pins.
module tb_psa_seq;

  localparam int LW  = 4;
  localparam int NL  = 4;
  localparam int LPC = 1;
  localparam int DW  = LW * NL;
  localparam int NCH = NL / LPC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [DW-1:0] A, B;
  logic          sub, sat_en;
  logic          busy, done, Error;
  logic [DW-1:0] Sum;
  logic [NL-1:0] lane_ovfl;

  psa_seq #(.LANE_W(LW), .NUM_LANES(NL), .LANES_PER_CYC(LPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .sub(sub), .sat_en(sat_en),
    .busy(busy), .done(done), .Sum(Sum), .lane_ovfl(lane_ovfl), .Error(Error)
  );

  // Fully parallel 8-bit-lane configuration
  logic        start2, sub2, sat2, busy2, done2, err2;
  logic [31:0] a2, b2, sum2;
  logic [3:0]  ovfl2;

  psa_seq #(.LANE_W(8), .NUM_LANES(4), .LANES_PER_CYC(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .sub(sub2), .sat_en(sat2),
    .busy(busy2), .done(done2), .Sum(sum2), .lane_ovfl(ovfl2), .Error(err2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: per-lane signed integer arithmetic, range-checked against LANE_W
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input logic sat, input int w, input int nl,
                                output logic [31:0] sum, output logic [7:0] ov);
    int av, bv, r, mx, mn, msk;
    sum = 32'd0;
    ov  = 8'd0;
    mx  = (1 << (w - 1)) - 1;
    mn  = -(1 << (w - 1));
    msk = (1 << w) - 1;
    for (int i = 0; i < nl; i++) begin
      av = int'((a >> (i * w)) & 32'(msk));
      bv = int'((b >> (i * w)) & 32'(msk));
      if (av > mx) av = av - (1 << w);
      if (bv > mx) bv = bv - (1 << w);
      r = s ? (av - bv) : (av + bv);
      if (r > mx || r < mn) begin
        ov[i] = 1'b1;
        if (sat) r = (r > mx) ? mx : mn;
      end
      sum = sum | (32'(r & msk) << (i * w));
    end
  endfunction

  // Timing model: chunks remaining, lanes revealed so far, one-cycle done
  int          m_left  = 0;
  int          m_lanes = 0;
  logic        m_done  = 1'b0;
  logic [31:0] m_sum   = 32'd0, m_full_sum = 32'd0;
  logic [7:0]  m_ovfl  = 8'd0,  m_full_ovfl = 8'd0;

  always @(posedge clk or negedge rst_n) begin : model_proc
    logic [31:0] fs;
    logic [7:0]  fo;
    if (!rst_n) begin
      m_left <= 0; m_lanes <= 0; m_done <= 1'b0; m_sum <= 32'd0; m_ovfl <= 8'd0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0 && !m_done) begin
        if (start) begin
          model(32'(A), 32'(B), sub, sat_en, LW, NL, fs, fo);
          m_full_sum  <= fs;
          m_full_ovfl <= fo;
          m_sum <= 32'd0; m_ovfl <= 8'd0; m_lanes <= 0; m_left <= NCH;
        end
      end else if (m_left > 0) begin
        m_sum   <= m_full_sum & ((32'd1 << ((m_lanes + LPC) * LW)) - 32'd1);
        m_ovfl  <= m_full_ovfl & ((8'd1 << (m_lanes + LPC)) - 8'd1);
        m_lanes <= m_lanes + LPC;
        m_left  <= m_left - 1;
        if (m_left == 1) m_done <= 1'b1;
      end
    end
  end

  // Per-cycle comparison away from the active edge
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left != 0));
    check("done", 32'(done), 32'(m_done));
    check("Sum", 32'(Sum), 32'(m_sum[DW-1:0]));
    check("lane_ovfl", 32'(lane_ovfl), 32'(m_ovfl[NL-1:0]));
    check("Error", 32'(Error), 32'(|m_ovfl[NL-1:0]));
  end

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s, input logic sat);
    A = a; B = b; sub = s; sat_en = sat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_dir(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic s, input logic sat, input logic [DW-1:0] exp_sum,
                         input logic [NL-1:0] exp_ov, input logic exp_err);
    int n;
    issue(a, b, s, sat);
    wait_done(n);
    check({name, "_latency"}, 32'(n), 32'(NCH));
    check({name, "_sum"}, 32'(Sum), 32'(exp_sum));
    check({name, "_ovfl"}, 32'(lane_ovfl), 32'(exp_ov));
    check({name, "_err"}, 32'(Error), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [31:0] fs;
    logic [7:0]  fo;
    int n;
    start = 1'b0; A = '0; B = '0; sub = 1'b0; sat_en = 1'b0;
    start2 = 1'b0; a2 = 32'd0; b2 = 32'd0; sub2 = 1'b0; sat2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_err", 32'(Error), 32'd0);

    // Pin the reference model itself
    model(32'h7777, 32'h1111, 1'b0, 1'b1, 4, 4, fs, fo);
    check("model_sat", fs, 32'h7777);
    model(32'h7F01_80FF, 32'h0101_FF01, 1'b0, 1'b1, 8, 4, fs, fo);
    check("model_w8", fs, 32'h7F02_8000);
    check("model_w8_ov", 32'(fo), 32'h0A);

    // Directed cases, back-to-back
    run_dir("add",      16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 4'h0, 1'b0);
    run_dir("add_sat",  16'h7777, 16'h1111, 1'b0, 1'b1, 16'h7777, 4'hF, 1'b1);
    run_dir("add_wrap", 16'h7777, 16'h1111, 1'b0, 1'b0, 16'h8888, 4'hF, 1'b1);
    run_dir("sub_sat",  16'h8000, 16'h1000, 1'b1, 1'b1, 16'h8000, 4'b1000, 1'b1);
    run_dir("sub_wrap", 16'h8000, 16'h1000, 1'b1, 1'b0, 16'h7000, 4'b1000, 1'b1);
    run_dir("sub_ok",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h800F, 4'h0, 1'b0);

    // start during BUSY is ignored
    issue(16'h1234, 16'h1111, 1'b0, 1'b1);
    @(posedge clk); #1;
    A = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("ign_sum", 32'(Sum), 32'h2345);
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    issue(16'h7777, 16'h1111, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_err", 32'(Error), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(Sum), 32'd0);
    check("mid_rst_err", 32'(Error), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_dir("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 4'h0, 1'b0);

    // Fully parallel configuration: done one edge after acceptance
    a2 = 32'h7F01_80FF; b2 = 32'h0101_FF01; sub2 = 1'b0; sat2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    check("w8_done", 32'(done2), 32'd1);
    check("w8_busy", 32'(busy2), 32'd0);
    check("w8_sum", sum2, 32'h7F02_8000);
    check("w8_ovfl", 32'(ovfl2), 32'hA);
    check("w8_err", 32'(err2), 32'd1);

    // Randomized operations with idle gaps and stray starts during BUSY
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        A = 16'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(n);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
